cpu_divide_sequencer: RTL and testbench
=======================================

// Module: cpu_divide_sequencer
// PURPOSE
//  Multi-cycle integer divide unit for the CPU execute stage: radix-2 restoring shift-subtract
//  divider plus the state machine that sequences it. Executes RV32M DIV/DIVU/REM/REMU with
//  request/ready issue handshake and one-cycle o_valid completion pulse. One operation in flight.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; also number of DIVIDE iterations
// PORTS
//  i_clock        in   1      clock; all state updates on rising edge
//  i_reset_n      in   1      asynchronous, active-low reset
//  i_request      in   1      issue request; operands and op sampled when accepted
//  i_op           in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0=unsigned, bit1=remainder)
//  i_numerator    in   WIDTH  dividend
//  i_denominator  in   WIDTH  divisor
//  o_ready        out  1      unit can accept a request this cycle
//  o_valid        out  1      one-cycle pulse: o_result holds completed result
//  o_result       out  WIDTH  quotient or remainder per op; held until next completion
// BEHAVIOUR
//  - Reset (async assert, any state incl. mid-divide): state=IDLE, counter=0, o_valid=0,
//    o_result=0, o_ready=1; in-flight operation discarded, no completion pulse.
//  - Accept = i_request && o_ready. o_ready=1 in IDLE and DONE, 0 otherwise. Requests while
//    busy are ignored (not queued); requester holds i_request until accepted.
//  - Accept: latch op; signed ops take |num|, |den| (two's-complement negate when bit WIDTH-1
//    set), record quotient sign = sn^sd, remainder sign = sn. Unsigned ops use raw values.
//  - States: IDLE -> DIVIDE (normal) | DONE (special case); DIVIDE -> FIXUP after WIDTH
//    iterations; FIXUP -> DONE; DONE -> IDLE, or -> DIVIDE/DONE if a request is accepted.
//  - DIVIDE iteration: {rem,quo} <<= 1; if rem >= den then rem -= den, quo[0]=1.
//    rem is WIDTH+1 bits internally to hold the compare; counter counts WIDTH-1 down to 0.
//  - FIXUP: negate quotient/remainder per recorded signs; select quotient or remainder by op.
//  - DONE: o_valid=1 for exactly one cycle; o_result updated on the edge entering DONE.
//  - Latency (accept edge to o_valid high): WIDTH+2 cycles normal; 1 cycle special case.
//  - Special cases (decided at accept, no iteration):
//    den==0: quotient = all ones (both signed/unsigned), remainder = numerator (unmodified).
//    signed, num==1<<(WIDTH-1), den==all ones: quotient = num, remainder = 0.
//  - Back-to-back: request accepted in DONE starts next op the following cycle; no bubble.
//  - Quotient/remainder of unsigned ops never sign-corrected; num==0 gives 0/0 at normal latency.
// CONFIGURATION
//  CPU_DIVIDE_CACHE_EN defined: unit keeps last completed {op-signedness, num, den, quotient,
//    remainder} (valid bit cleared on reset). Accept with matching signedness, num and den
//    goes straight to DONE (latency 1) returning quotient or remainder per new op; so REM
//    after DIV of same operands costs 1 cycle. Special-case results are also cached.
//  CPU_DIVIDE_CACHE_EN undefined: no cache storage; every normal op takes WIDTH+2 cycles.
//  Result values identical in both builds; only latency differs.
// TESTING
//  1. DIVU 100/7 -> o_valid 34 cycles after accept, o_result=14; REMU same -> 2.
//  2. DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
//  3. DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, each 1 cycle after accept; DIV 0x80000000/-1 ->
//     0x80000000, REM -> 0, 1 cycle.
//  4. Request held during busy: second request ignored until DONE, accepted in DONE cycle,
//     completes 34 cycles later; exactly one o_valid pulse per accepted request.
//  5. Assert i_reset_n=0 at iteration 10 of DIVU 1000/3 -> o_valid never pulses, o_result=0,
//     o_ready=1 immediately; fresh DIVU 9/3 then returns 3 at normal latency.
//  6. CACHE_EN: DIV 100/7 (34 cyc, 14) then REM 100/7 -> 2 in 1 cycle; DIVU 100/7 -> 34 cyc
//     (signedness differs); without macro all three take 34 cycles.

Source files
------------

// File: rtl/cpu_divide_sequencer.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with request/ready issue.
// Optional result cache for repeated operands is enabled by defining CPU_DIVIDE_CACHE_EN.
module cpu_divide_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_request,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_numerator,
  input  logic [WIDTH-1:0] i_denominator,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] den_r;
  logic [1:0]       op_r;
  logic             q_neg_r;
  logic             r_neg_r;

  logic             accept_s;
  logic             is_signed_s;
  logic             num_neg_s;
  logic             den_neg_s;
  logic [WIDTH-1:0] num_abs_s;
  logic [WIDTH-1:0] den_abs_s;
  logic             den_zero_s;
  logic             ovf_s;
  logic             special_s;
  logic             shortcut_s;
  logic [WIDTH-1:0] sp_quo_s;
  logic [WIDTH-1:0] sp_rem_s;
  logic [WIDTH-1:0] shortcut_res_s;
  logic             hit_s;
  logic [WIDTH-1:0] hit_quo_s;
  logic [WIDTH-1:0] hit_rem_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] quo_fin_s;
  logic [WIDTH-1:0] rem_fin_s;

  // Operand conditioning and special-case detection at issue
  always_comb begin
    accept_s    = i_request && o_ready;
    is_signed_s = ~i_op[0];
    num_neg_s   = is_signed_s & i_numerator[WIDTH-1];
    den_neg_s   = is_signed_s & i_denominator[WIDTH-1];
    num_abs_s   = num_neg_s ? negate(i_numerator) : i_numerator;
    den_abs_s   = den_neg_s ? negate(i_denominator) : i_denominator;
    den_zero_s  = (i_denominator == ZERO);
    ovf_s       = is_signed_s && (i_numerator == MIN_NEG) && (i_denominator == ONES);
    special_s   = den_zero_s | ovf_s;
    if (den_zero_s) begin
      sp_quo_s = ONES;
      sp_rem_s = i_numerator;
    end else if (ovf_s) begin
      sp_quo_s = i_numerator;
      sp_rem_s = ZERO;
    end else begin
      sp_quo_s = hit_quo_s;
      sp_rem_s = hit_rem_s;
    end
    shortcut_s     = special_s | hit_s;
    shortcut_res_s = i_op[1] ? sp_rem_s : sp_quo_s;
  end

  // One shift-subtract step; the borrow of the (WIDTH+1)-bit subtract is the compare result
  always_comb begin
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    diff_s     = shifted_s - {1'b0, den_r};
    ge_s       = ~diff_s[WIDTH];
    rem_next_s = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    quo_next_s = {quo_r[WIDTH-2:0], ge_s};
    quo_fin_s  = q_neg_r ? negate(quo_r) : quo_r;
    rem_fin_s  = r_neg_r ? negate(rem_r) : rem_r;
  end

  // Sequencer state, datapath registers and registered handshake outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      rem_r    <= ZERO;
      quo_r    <= ZERO;
      den_r    <= ZERO;
      op_r     <= 2'b00;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= ZERO;
      o_ready  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          o_valid <= 1'b0;
          if (accept_s) begin
            op_r    <= i_op;
            q_neg_r <= num_neg_s ^ den_neg_s;
            r_neg_r <= num_neg_s;
            rem_r   <= ZERO;
            quo_r   <= num_abs_s;
            den_r   <= den_abs_s;
            cnt_r   <= CNT_TOP;
            if (shortcut_s) begin
              state_r  <= ST_DONE;
              o_valid  <= 1'b1;
              o_result <= shortcut_res_s;
              o_ready  <= 1'b1;
            end else begin
              state_r <= ST_DIVIDE;
              o_ready <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            o_ready <= 1'b1;
          end
        end
        ST_DIVIDE: begin
          rem_r   <= rem_next_s;
          quo_r   <= quo_next_s;
          o_ready <= 1'b0;
          o_valid <= 1'b0;
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= ST_FIXUP;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_FIXUP: begin
          o_result <= op_r[1] ? rem_fin_s : quo_fin_s;
          o_valid  <= 1'b1;
          o_ready  <= 1'b1;
          state_r  <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CPU_DIVIDE_CACHE_EN
  logic             cache_vld_r;
  logic             cache_sgn_r;
  logic [WIDTH-1:0] cache_num_r;
  logic [WIDTH-1:0] cache_den_r;
  logic [WIDTH-1:0] cache_quo_r;
  logic [WIDTH-1:0] cache_rem_r;
  logic             pend_sgn_r;
  logic [WIDTH-1:0] pend_num_r;
  logic [WIDTH-1:0] pend_den_r;

  assign hit_s = cache_vld_r && (cache_sgn_r == is_signed_s) &&
                 (cache_num_r == i_numerator) && (cache_den_r == i_denominator);
  assign hit_quo_s = cache_quo_r;
  assign hit_rem_s = cache_rem_r;

  // Remember the last completed operation; the key is captured at issue, results at fixup
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cache_vld_r <= 1'b0;
      cache_sgn_r <= 1'b0;
      cache_num_r <= ZERO;
      cache_den_r <= ZERO;
      cache_quo_r <= ZERO;
      cache_rem_r <= ZERO;
      pend_sgn_r  <= 1'b0;
      pend_num_r  <= ZERO;
      pend_den_r  <= ZERO;
    end else begin
      if (accept_s) begin
        pend_sgn_r <= is_signed_s;
        pend_num_r <= i_numerator;
        pend_den_r <= i_denominator;
      end else begin
        pend_sgn_r <= pend_sgn_r;
      end
      if (accept_s && special_s) begin
        cache_vld_r <= 1'b1;
        cache_sgn_r <= is_signed_s;
        cache_num_r <= i_numerator;
        cache_den_r <= i_denominator;
        cache_quo_r <= sp_quo_s;
        cache_rem_r <= sp_rem_s;
      end else if (state_r == ST_FIXUP) begin
        cache_vld_r <= 1'b1;
        cache_sgn_r <= pend_sgn_r;
        cache_num_r <= pend_num_r;
        cache_den_r <= pend_den_r;
        cache_quo_r <= quo_fin_s;
        cache_rem_r <= rem_fin_s;
      end else begin
        cache_vld_r <= cache_vld_r;
      end
    end
  end
`else
  assign hit_s     = 1'b0;
  assign hit_quo_s = ZERO;
  assign hit_rem_s = ZERO;
`endif

endmodule

// File: tb/tb_cpu_divide_sequencer.sv
// Scoreboard bench for cpu_divide_sequencer: directed RV32M cases plus random operations,
// checked for result value and accept-to-valid latency against an arithmetic reference model.
module tb_cpu_divide_sequencer;

  localparam int W = 32;
`ifdef CPU_DIVIDE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_request = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic [W-1:0]  i_numerator = '0;
  logic [W-1:0]  i_denominator = '0;
  logic          o_ready;
  logic          o_valid;
  logic [W-1:0]  o_result;

  cpu_divide_sequencer #(.WIDTH(W)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_request(i_request), .i_op(i_op),
    .i_numerator(i_numerator), .i_denominator(i_denominator),
    .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    logic [1:0]   op;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;

  bit           m_vld = 1'b0;
  bit           m_sgn = 1'b0;
  logic [W-1:0] m_num = '0;
  logic [W-1:0] m_den = '0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] n,
                                              input logic [W-1:0] d);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = n;
    end else if (!op[0] && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = n;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(n) / $signed(d);
      r = $signed(n) % $signed(d);
    end else begin
      q = n / d;
      r = n % d;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] n,
                                     input logic [W-1:0] d);
    bit special;
    bit hit;
    special = (d == 32'd0) || (!op[0] && n == 32'h8000_0000 && d == 32'hFFFF_FFFF);
    hit = CACHE && m_vld && (m_sgn == !op[0]) && (m_num == n) && (m_den == d);
    return (special || hit) ? 1 : W + 2;
  endfunction

  // Called at a falling edge; holds the request until accepted, returns one falling edge later.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] n, input logic [W-1:0] d);
    int   waited;
    exp_t e;
    waited = 0;
    i_request = 1'b1;
    i_op = op;
    i_numerator = n;
    i_denominator = d;
    while (!o_ready && waited < 200) begin
      @(negedge i_clock);
      waited++;
    end
    if (!o_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      i_request = 1'b0;
      return;
    end
    e.res = ref_result(op, n, d);
    e.lat = ref_latency(op, n, d);
    e.acc = cyc;
    e.op  = op;
    sb.push_back(e);
    m_vld = 1'b1;
    m_sgn = !op[0];
    m_num = n;
    m_den = d;
    @(negedge i_clock);
    i_request = 1'b0;
  endtask

  // Monitor: every completion pulse is matched against the oldest outstanding expectation
  always @(negedge i_clock) begin
    if (i_reset_n && o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", o_result, e.res);
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] n;
    logic [W-1:0] d;
    int           w;

    repeat (2) @(negedge i_clock);
    check("reset_ready", {31'd0, o_ready}, 32'd1);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clock);

    // Basic unsigned and signed cases; DIVU/REMU issued back-to-back
    issue(2'b01, 32'd100, 32'd7);
    issue(2'b11, 32'd100, 32'd7);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b00, 32'd7, 32'hFFFF_FFFE);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    // Divide by zero and signed overflow
    issue(2'b00, 32'd5, 32'd0);
    issue(2'b10, 32'd5, 32'd0);
    issue(2'b01, 32'hDEAD_BEEF, 32'd0);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b00, 32'd0, 32'd9);
    // Signedness change on identical operands
    issue(2'b00, 32'd100, 32'd7);
    issue(2'b10, 32'd100, 32'd7);
    issue(2'b01, 32'd100, 32'd7);
    repeat (40) @(negedge i_clock);

    // Reset in the middle of an iteration sequence
    issue(2'b01, 32'd1000, 32'd3);
    repeat (9) @(negedge i_clock);
    i_reset_n = 1'b0;
    sb.delete();
    m_vld = 1'b0;
    #1;
    check("midreset_ready", {31'd0, o_ready}, 32'd1);
    check("midreset_valid", {31'd0, o_valid}, 32'd0);
    check("midreset_result", o_result, 32'd0);
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);
    issue(2'b01, 32'd9, 32'd3);
    repeat (36) @(negedge i_clock);

    // Random operations with occasional repeated operands and idle gaps
    n = 32'd1;
    d = 32'd1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: begin n = $urandom; d = 32'd0; end
        1: begin n = $urandom; d = 32'($urandom_range(1, 20)); if ($urandom_range(0, 1) == 1) d = -d; end
        2: begin n = 32'h8000_0000; d = 32'hFFFF_FFFF; end
        3: begin n = n; d = d; end
        4: begin n = 32'($urandom_range(0, 50)); d = $urandom; end
        default: begin n = $urandom; d = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(op, n, d);
      repeat ($urandom_range(0, 2) * $urandom_range(0, 20)) @(negedge i_clock);
    end

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge i_clock);
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge i_clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
